axi_wr_rd_arb2: RTL and testbench

- Two-requester AXI arbiter placed in front of the decrement-to-increment burst converter.
- Lets two upstream masters (e.g. C910 core port and DMA port) share one downstream AXI port.
- Round-robin arbitration on AW and AR independently. W, B and R are steered by in-order routing FIFOs.
- Downstream returns B and R strictly in request order (single-ID, in-order slave); IDs pass through unmodified.

---
 rtl/axi_wr_rd_arb2.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_axi_wr_rd_arb2.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_rd_arb2.sv
// Two-requester AXI arbiter: round-robin AW/AR grant with hold-until-handshake,
// W/B/R steered back to the right requester through in-order port-index FIFOs.
package axi_wr_rd_arb2_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;
endpackage

// 1-bit port-index FIFO; pointers wrap naturally, a separate counter gives full/empty.
module axi_wr_rd_arb2_idx_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// Address-channel arbiter: grant held while valid waits for ready, priority flips on handshake.
module axi_wr_rd_arb2_addr_arb #(
  parameter type chan_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  valid0_i,
  input  logic  valid1_i,
  input  chan_t chan0_i,
  input  chan_t chan1_i,
  input  logic  elig_i,
  input  logic  mst_ready_i,
  output logic  sel_o,
  output logic  mst_valid_o,
  output logic  hs_o,
  output chan_t chan_o
);
  logic rr_q, rr_d;
  logic lock_q, lock_d;
  logic sel_q, sel_d;
  logic req_valid_s;

  // Grant selection: a held grant wins, otherwise the lone requester or the preferred port.
  always_comb begin
    if (lock_q) begin
      sel_o = sel_q;
    end else if (valid0_i && valid1_i) begin
      sel_o = rr_q;
    end else if (valid1_i) begin
      sel_o = 1'b1;
    end else begin
      sel_o = 1'b0;
    end
  end

  assign req_valid_s = sel_o ? valid1_i : valid0_i;
  assign chan_o      = sel_o ? chan1_i : chan0_i;
  assign mst_valid_o = req_valid_s && elig_i;
  assign hs_o        = mst_valid_o && mst_ready_i;

  // Lock/priority update.
  always_comb begin
    rr_d   = rr_q;
    lock_d = lock_q;
    sel_d  = sel_q;
    if (hs_o) begin
      lock_d = 1'b0;
      rr_d   = ~sel_o;
    end else if (mst_valid_o) begin
      lock_d = 1'b1;
      sel_d  = sel_o;
    end else begin
      lock_d = lock_q;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= 1'b0;
      lock_q <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      lock_q <= lock_d;
      sel_q  <= sel_d;
    end
  end
endmodule

// Simulation-only protocol check: downstream must not return B with no write outstanding.
module axi_wr_rd_arb2_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic b_valid_i,
  input logic b_empty_i
);
  a_no_orphan_b: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_valid_i && b_empty_i))
    else $error("B response received with no outstanding write");
endmodule

module axi_wr_rd_arb2 #(
  parameter int unsigned MaxTxns = 4,
  parameter type aw_chan_t  = axi_wr_rd_arb2_pkg::aw_chan_t,
  parameter type w_chan_t   = axi_wr_rd_arb2_pkg::w_chan_t,
  parameter type b_chan_t   = axi_wr_rd_arb2_pkg::b_chan_t,
  parameter type ar_chan_t  = axi_wr_rd_arb2_pkg::ar_chan_t,
  parameter type r_chan_t   = axi_wr_rd_arb2_pkg::r_chan_t,
  parameter type axi_req_t  = axi_wr_rd_arb2_pkg::axi_req_t,
  parameter type axi_resp_t = axi_wr_rd_arb2_pkg::axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv0_req_i,
  output axi_resp_t slv0_resp_o,
  input  axi_req_t  slv1_req_i,
  output axi_resp_t slv1_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);
  aw_chan_t aw_pl_s;
  ar_chan_t ar_pl_s;
  w_chan_t  w_pl_s;
  b_chan_t  b_pl_s;
  r_chan_t  r_pl_s;

  logic aw_sel_s, aw_valid_s, aw_hs_s, aw_elig_s, aw_rdy_s;
  logic ar_sel_s, ar_valid_s, ar_hs_s, ar_elig_s, ar_rdy_s;
  logic w_full_s, w_empty_s, w_head_s, w_valid_s, w_rdy_s, w_pop_s;
  logic b_full_s, b_empty_s, b_head_s, b_valid_s, b_rdy_s, b_pop_s;
  logic r_full_s, r_empty_s, r_head_s, r_valid_s, r_rdy_s, r_pop_s;

  // A full routing FIFO blocks the grant even if it pops this cycle, so grant never depends on ready.
  assign aw_elig_s = !w_full_s && !b_full_s;
  assign ar_elig_s = !r_full_s;
  assign aw_rdy_s  = aw_elig_s && mst_resp_i.aw_ready;
  assign ar_rdy_s  = ar_elig_s && mst_resp_i.ar_ready;

  axi_wr_rd_arb2_addr_arb #(.chan_t(aw_chan_t)) u_aw_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid0_i    (slv0_req_i.aw_valid),
    .valid1_i    (slv1_req_i.aw_valid),
    .chan0_i     (slv0_req_i.aw),
    .chan1_i     (slv1_req_i.aw),
    .elig_i      (aw_elig_s),
    .mst_ready_i (mst_resp_i.aw_ready),
    .sel_o       (aw_sel_s),
    .mst_valid_o (aw_valid_s),
    .hs_o        (aw_hs_s),
    .chan_o      (aw_pl_s)
  );

  axi_wr_rd_arb2_addr_arb #(.chan_t(ar_chan_t)) u_ar_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid0_i    (slv0_req_i.ar_valid),
    .valid1_i    (slv1_req_i.ar_valid),
    .chan0_i     (slv0_req_i.ar),
    .chan1_i     (slv1_req_i.ar),
    .elig_i      (ar_elig_s),
    .mst_ready_i (mst_resp_i.ar_ready),
    .sel_o       (ar_sel_s),
    .mst_valid_o (ar_valid_s),
    .hs_o        (ar_hs_s),
    .chan_o      (ar_pl_s)
  );

  axi_wr_rd_arb2_idx_fifo #(.Depth(MaxTxns)) u_w_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs_s),
    .data_i  (aw_sel_s),
    .pop_i   (w_pop_s),
    .full_o  (w_full_s),
    .empty_o (w_empty_s),
    .head_o  (w_head_s)
  );

  axi_wr_rd_arb2_idx_fifo #(.Depth(MaxTxns)) u_b_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs_s),
    .data_i  (aw_sel_s),
    .pop_i   (b_pop_s),
    .full_o  (b_full_s),
    .empty_o (b_empty_s),
    .head_o  (b_head_s)
  );

  axi_wr_rd_arb2_idx_fifo #(.Depth(MaxTxns)) u_r_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ar_hs_s),
    .data_i  (ar_sel_s),
    .pop_i   (r_pop_s),
    .full_o  (r_full_s),
    .empty_o (r_empty_s),
    .head_o  (r_head_s)
  );

  axi_wr_rd_arb2_chk u_chk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .b_valid_i (mst_resp_i.b_valid),
    .b_empty_i (b_empty_s)
  );

  // W follows the oldest accepted AW; an empty FIFO keeps W from overtaking its address.
  assign w_pl_s    = w_head_s ? slv1_req_i.w : slv0_req_i.w;
  assign w_valid_s = !w_empty_s && (w_head_s ? slv1_req_i.w_valid : slv0_req_i.w_valid);
  assign w_rdy_s   = !w_empty_s && mst_resp_i.w_ready;
  assign w_pop_s   = w_valid_s && mst_resp_i.w_ready && w_pl_s.last;

  assign b_pl_s    = mst_resp_i.b;
  assign b_valid_s = !b_empty_s && mst_resp_i.b_valid;
  assign b_rdy_s   = !b_empty_s && (b_head_s ? slv1_req_i.b_ready : slv0_req_i.b_ready);
  assign b_pop_s   = b_valid_s && b_rdy_s;

  assign r_pl_s    = mst_resp_i.r;
  assign r_valid_s = !r_empty_s && mst_resp_i.r_valid;
  assign r_rdy_s   = !r_empty_s && (r_head_s ? slv1_req_i.r_ready : slv0_req_i.r_ready);
  assign r_pop_s   = r_valid_s && r_rdy_s && r_pl_s.last;

  // Output assembly; every handshake signal is forced low while reset is asserted.
  always_comb begin
    mst_req_o   = '0;
    slv0_resp_o = '0;
    slv1_resp_o = '0;
    mst_req_o.aw  = aw_pl_s;
    mst_req_o.w   = w_pl_s;
    mst_req_o.ar  = ar_pl_s;
    slv0_resp_o.b = b_pl_s;
    slv1_resp_o.b = b_pl_s;
    slv0_resp_o.r = r_pl_s;
    slv1_resp_o.r = r_pl_s;
    if (rst_ni) begin
      mst_req_o.aw_valid   = aw_valid_s;
      mst_req_o.w_valid    = w_valid_s;
      mst_req_o.b_ready    = b_rdy_s;
      mst_req_o.ar_valid   = ar_valid_s;
      mst_req_o.r_ready    = r_rdy_s;
      slv0_resp_o.aw_ready = !aw_sel_s && aw_rdy_s;
      slv1_resp_o.aw_ready = aw_sel_s && aw_rdy_s;
      slv0_resp_o.ar_ready = !ar_sel_s && ar_rdy_s;
      slv1_resp_o.ar_ready = ar_sel_s && ar_rdy_s;
      slv0_resp_o.w_ready  = !w_head_s && w_rdy_s;
      slv1_resp_o.w_ready  = w_head_s && w_rdy_s;
      slv0_resp_o.b_valid  = !b_head_s && b_valid_s;
      slv1_resp_o.b_valid  = b_head_s && b_valid_s;
      slv0_resp_o.r_valid  = !r_head_s && r_valid_s;
      slv1_resp_o.r_valid  = r_head_s && r_valid_s;
    end else begin
      mst_req_o.aw_valid = 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_wr_rd_arb2.sv
// Bench for axi_wr_rd_arb2: AW arbitration vector table plus scoreboarded W/B/R routing sequences.
module tb_axi_wr_rd_arb2;
  import axi_wr_rd_arb2_pkg::*;

  logic      clk;
  logic      rst_n;
  axi_req_t  s0_req, s1_req, mst_req;
  axi_resp_t s0_resp, s1_resp, mst_resp;

  int n_checks = 0;
  int n_fail   = 0;
  logic p;
  logic wq[$];
  logic bq[$];
  logic rq[$];

  typedef struct packed {
    logic       s0v;
    logic       s1v;
    logic       rdy;
    logic       e_mv;
    logic [3:0] e_id;
    logic       e_r0;
    logic       e_r1;
  } vec_t;
  vec_t tbl [0:4];

  axi_wr_rd_arb2 #(.MaxTxns(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .slv0_req_i  (s0_req),
    .slv0_resp_o (s0_resp),
    .slv1_req_i  (s1_req),
    .slv1_resp_o (s1_resp),
    .mst_req_o   (mst_req),
    .mst_resp_i  (mst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_valids();
    s0_req.aw_valid = 1'b0; s1_req.aw_valid = 1'b0;
    s0_req.w_valid  = 1'b0; s1_req.w_valid  = 1'b0;
    s0_req.ar_valid = 1'b0; s1_req.ar_valid = 1'b0;
    s0_req.b_ready  = 1'b0; s1_req.b_ready  = 1'b0;
    s0_req.r_ready  = 1'b0; s1_req.r_ready  = 1'b0;
    mst_resp.aw_ready = 1'b0; mst_resp.ar_ready = 1'b0; mst_resp.w_ready = 1'b0;
    mst_resp.b_valid  = 1'b0; mst_resp.r_valid  = 1'b0;
  endtask

  // One single-beat W per expected port; both ports offer data, only the head may pass.
  task automatic drain_w();
    logic hp;
    while (wq.size() > 0) begin
      hp = wq.pop_front();
      step();
      s0_req.w_valid = 1'b1; s0_req.w.data = 64'hA0A0; s0_req.w.last = 1'b1;
      s1_req.w_valid = 1'b1; s1_req.w.data = 64'hB1B1; s1_req.w.last = 1'b1;
      mst_resp.w_ready = 1'b1;
      settle();
      chk1("w_valid", mst_req.w_valid, 1'b1);
      chk64("w_data", mst_req.w.data, hp ? 64'hB1B1 : 64'hA0A0);
      chk1("w_ready0", s0_resp.w_ready, !hp);
      chk1("w_ready1", s1_resp.w_ready, hp);
    end
    step();
    s0_req.w_valid = 1'b0; s1_req.w_valid = 1'b0; mst_resp.w_ready = 1'b0;
  endtask

  task automatic drain_b();
    logic hp;
    while (bq.size() > 0) begin
      hp = bq.pop_front();
      step();
      mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'h3;
      s0_req.b_ready = 1'b1; s1_req.b_ready = 1'b1;
      settle();
      chk1("b_valid0", s0_resp.b_valid, !hp);
      chk1("b_valid1", s1_resp.b_valid, hp);
      chk1("b_ready_mst", mst_req.b_ready, 1'b1);
      chk64("b_id_bcast", 64'(s1_resp.b.id), 64'h3);
    end
    step();
    mst_resp.b_valid = 1'b0; s0_req.b_ready = 1'b0; s1_req.b_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0};

    s0_req = '0; s1_req = '0; mst_resp = '0;
    s0_req.aw.id = 4'hA; s1_req.aw.id = 4'h5;
    s0_req.ar.id = 4'hA; s1_req.ar.id = 4'h5;

    // Reset: everything handshake-related must be low despite active inputs.
    rst_n = 1'b0;
    s0_req.aw_valid = 1'b1; s0_req.w_valid = 1'b1; s1_req.ar_valid = 1'b1;
    s0_req.b_ready = 1'b1; s0_req.r_ready = 1'b1;
    mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1; mst_resp.w_ready = 1'b1;
    mst_resp.b_valid = 1'b1; mst_resp.r_valid = 1'b1;
    #2;
    chk1("rst_aw_valid", mst_req.aw_valid, 1'b0);
    chk1("rst_w_valid", mst_req.w_valid, 1'b0);
    chk1("rst_ar_valid", mst_req.ar_valid, 1'b0);
    chk1("rst_b_ready", mst_req.b_ready, 1'b0);
    chk1("rst_r_ready", mst_req.r_ready, 1'b0);
    chk1("rst_aw_ready0", s0_resp.aw_ready, 1'b0);
    chk1("rst_ar_ready1", s1_resp.ar_ready, 1'b0);
    chk1("rst_w_ready0", s0_resp.w_ready, 1'b0);
    chk1("rst_b_valid0", s0_resp.b_valid, 1'b0);
    chk1("rst_r_valid0", s0_resp.r_valid, 1'b0);
    clear_valids();
    @(negedge clk);
    rst_n = 1'b1;

    // AW round-robin with continuous requests until the routing FIFOs fill.
    for (int i = 0; i < 5; i++) begin
      step();
      s0_req.aw_valid = tbl[i].s0v;
      s1_req.aw_valid = tbl[i].s1v;
      mst_resp.aw_ready = tbl[i].rdy;
      settle();
      chk1("tbl_aw_valid", mst_req.aw_valid, tbl[i].e_mv);
      chk64("tbl_aw_id", 64'(mst_req.aw.id), 64'(tbl[i].e_id));
      chk1("tbl_aw_ready0", s0_resp.aw_ready, tbl[i].e_r0);
      chk1("tbl_aw_ready1", s1_resp.aw_ready, tbl[i].e_r1);
      if (tbl[i].e_mv && tbl[i].rdy) begin
        wq.push_back(tbl[i].e_r1);
        bq.push_back(tbl[i].e_r1);
      end
    end
    drain_w();
    settle();
    chk1("aw_blocked_bfull", mst_req.aw_valid, 1'b0);
    chk1("aw_ready0_blocked", s0_resp.aw_ready, 1'b0);
    step();
    mst_resp.b_valid = 1'b1; s0_req.b_ready = 1'b1; s1_req.b_ready = 1'b1;
    settle();
    p = bq.pop_front();
    chk1("b_first_route0", s0_resp.b_valid, !p);
    chk1("b_first_route1", s1_resp.b_valid, p);
    chk1("aw_no_pushthrough", mst_req.aw_valid, 1'b0);
    step();
    mst_resp.b_valid = 1'b0; s0_req.b_ready = 1'b0; s1_req.b_ready = 1'b0;
    settle();
    chk1("aw_after_b_valid", mst_req.aw_valid, 1'b1);
    chk64("aw_after_b_id", 64'(mst_req.aw.id), 64'hA);
    chk1("aw_after_b_ready0", s0_resp.aw_ready, 1'b1);
    wq.push_back(1'b0); bq.push_back(1'b0);
    step();
    s0_req.aw_valid = 1'b0; s1_req.aw_valid = 1'b0; mst_resp.aw_ready = 1'b0;
    drain_w();
    drain_b();

    // Grant hold: port0 stalled five cycles while port1 (now preferred) requests.
    step();
    s0_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b0;
    settle();
    chk1("lock_valid", mst_req.aw_valid, 1'b1);
    chk64("lock_id0", 64'(mst_req.aw.id), 64'hA);
    for (int k = 1; k < 5; k++) begin
      step();
      s1_req.aw_valid = 1'b1;
      settle();
      chk64("lock_id_hold", 64'(mst_req.aw.id), 64'hA);
      chk1("lock_ready1", s1_resp.aw_ready, 1'b0);
    end
    step();
    mst_resp.aw_ready = 1'b1;
    settle();
    chk64("lock_hs_id", 64'(mst_req.aw.id), 64'hA);
    chk1("lock_hs_ready0", s0_resp.aw_ready, 1'b1);
    wq.push_back(1'b0); bq.push_back(1'b0);
    step();
    s0_req.aw_valid = 1'b0;
    settle();
    chk64("lock_next_id", 64'(mst_req.aw.id), 64'h5);
    chk1("lock_next_ready1", s1_resp.aw_ready, 1'b1);
    wq.push_back(1'b1); bq.push_back(1'b1);
    step();
    s1_req.aw_valid = 1'b0; mst_resp.aw_ready = 1'b0;
    drain_w();
    drain_b();

    // Port1 burst len=3: W only after the AW, wlast empties the FIFO, B to port1 only.
    step();
    s1_req.aw_valid = 1'b1; s1_req.aw.len = 8'd3; mst_resp.aw_ready = 1'b1;
    s1_req.w_valid = 1'b1; s1_req.w.data = 64'h0; s1_req.w.last = 1'b0;
    mst_resp.w_ready = 1'b1;
    settle();
    chk1("p1_aw_valid", mst_req.aw_valid, 1'b1);
    chk1("p1_aw_ready", s1_resp.aw_ready, 1'b1);
    chk1("w_no_overtake", mst_req.w_valid, 1'b0);
    chk1("w_no_overtake_rdy", s1_resp.w_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      s1_req.aw_valid = 1'b0; mst_resp.aw_ready = 1'b0;
      s1_req.w.data = 64'(i) + 64'h50; s1_req.w.last = (i == 3);
      settle();
      chk1("p1_w_valid", mst_req.w_valid, 1'b1);
      chk64("p1_w_data", mst_req.w.data, 64'(i) + 64'h50);
      chk1("p1_w_ready1", s1_resp.w_ready, 1'b1);
      chk1("p1_w_ready0", s0_resp.w_ready, 1'b0);
    end
    step();
    settle();
    chk1("w_empty_after_last", mst_req.w_valid, 1'b0);
    chk1("w_empty_ready1", s1_resp.w_ready, 1'b0);
    step();
    s1_req.w_valid = 1'b0; mst_resp.w_ready = 1'b0;
    mst_resp.b_valid = 1'b1; s0_req.b_ready = 1'b1; s1_req.b_ready = 1'b1;
    settle();
    chk1("p1_b_valid1", s1_resp.b_valid, 1'b1);
    chk1("p1_b_valid0", s0_resp.b_valid, 1'b0);
    step();
    mst_resp.b_valid = 1'b0;
    settle();
    chk1("b_fifo_empty", mst_req.b_ready, 1'b0);
    step();
    s0_req.b_ready = 1'b0; s1_req.b_ready = 1'b0; s1_req.aw.len = 8'd0;

    // AR from both ports (port0 len 1, port1 len 0); R beats routed in order.
    step();
    s0_req.ar_valid = 1'b1; s0_req.ar.len = 8'd1;
    s1_req.ar_valid = 1'b1; s1_req.ar.len = 8'd0;
    mst_resp.ar_ready = 1'b1;
    settle();
    chk64("ar0_id", 64'(mst_req.ar.id), 64'hA);
    chk1("ar0_ready0", s0_resp.ar_ready, 1'b1);
    chk1("ar0_ready1", s1_resp.ar_ready, 1'b0);
    for (int b = 0; b <= 1; b++) rq.push_back(1'b0);
    step();
    s0_req.ar_valid = 1'b0;
    settle();
    chk64("ar1_id", 64'(mst_req.ar.id), 64'h5);
    chk1("ar1_ready1", s1_resp.ar_ready, 1'b1);
    rq.push_back(1'b1);
    step();
    s1_req.ar_valid = 1'b0; mst_resp.ar_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p = rq.pop_front();
      step();
      mst_resp.r_valid = 1'b1; mst_resp.r.last = (i != 0); mst_resp.r.data = 64'(i) + 64'h100;
      s0_req.r_ready = 1'b1; s1_req.r_ready = 1'b1;
      settle();
      chk1("r_valid0", s0_resp.r_valid, !p);
      chk1("r_valid1", s1_resp.r_valid, p);
      chk1("r_ready_mst", mst_req.r_ready, 1'b1);
      chk64("r_data_bcast", s0_resp.r.data, 64'(i) + 64'h100);
    end
    step();
    mst_resp.r_valid = 1'b0;
    settle();
    chk1("r_fifo_empty", mst_req.r_ready, 1'b0);
    step();
    s0_req.r_ready = 1'b0; s1_req.r_ready = 1'b0;

    // Reset with two writes outstanding, then a fresh port1 write.
    step();
    s0_req.aw_valid = 1'b1; s1_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    settle();
    chk64("pre_rst_aw0", 64'(mst_req.aw.id), 64'hA);
    step();
    s0_req.aw_valid = 1'b0;
    settle();
    chk64("pre_rst_aw1", 64'(mst_req.aw.id), 64'h5);
    step();
    s1_req.aw_valid = 1'b0; s0_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b0;
    s0_req.w_valid = 1'b1; s0_req.w.last = 1'b1; mst_resp.w_ready = 1'b0;
    settle();
    chk1("pre_rst_w_valid", mst_req.w_valid, 1'b1);
    rst_n = 1'b0;
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    #1;
    chk1("async_rst_w_valid", mst_req.w_valid, 1'b0);
    chk1("async_rst_w_ready0", s0_resp.w_ready, 1'b0);
    chk1("async_rst_aw_valid", mst_req.aw_valid, 1'b0);
    chk1("async_rst_aw_ready0", s0_resp.aw_ready, 1'b0);
    clear_valids();
    wq.delete(); bq.delete();
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    s1_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    settle();
    chk1("post_rst_aw_valid", mst_req.aw_valid, 1'b1);
    chk64("post_rst_aw_id", 64'(mst_req.aw.id), 64'h5);
    chk1("post_rst_aw_ready1", s1_resp.aw_ready, 1'b1);
    wq.push_back(1'b1); bq.push_back(1'b1);
    step();
    s1_req.aw_valid = 1'b0; mst_resp.aw_ready = 1'b0;
    drain_w();
    drain_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
